// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the status LED scheduler.
// Contents: FSM state type, blink-code width, solid-on code, default timing constants
// and a small max helper used for sizing counters.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSolid,
    StOn,
    StOff,
    StGap
  } led_state_e;

  localparam int unsigned CodeW = 4;
  localparam logic [CodeW-1:0] SolidCode = '0;

  localparam int unsigned DefClkFreqHz  = 50_000_000;
  localparam int unsigned DefTickHz     = 100;
  localparam int unsigned DefPulseTicks = 25;
  localparam int unsigned DefGapTicks   = 150;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern time-base prescaler.
// Counts 0..DIV-1 and flags tick while the count sits at DIV-1, then wraps.
// Ports:
//   sys_clk  system clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous clear back to 0 (used on every FSM state entry)
//   tick     high for one cycle every DIV cycles
module led_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CntLast)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/led_status_sched.sv
// Status LED scheduler: shares one LED between NUM_REQ requesters.
// Fixed priority (bit 0 highest) picks an owner in IDLE; the FSM then plays either a
// solid-on indication (code 0) or an N-pulse blink code followed by a gap.
// Ports:
//   sys_clk  system clock
//   rst_n    asynchronous active-low reset
//   req      level request per requester
//   code     4-bit blink code per requester (nibble i for req[i]); 0 = solid on
//   grant    one-hot LED owner, zero when idle (registered)
//   busy     high whenever the FSM is not idle (registered)
//   led      LED drive (registered)
// Build option: define LED_ACTIVE_LOW_EN to invert led for active-low wiring
// (reset/idle level 1); grant, busy and all timing are unchanged.
module led_status_sched
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DefClkFreqHz,
  parameter int unsigned TICK_HZ     = DefTickHz,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PULSE_TICKS = DefPulseTicks,
  parameter int unsigned GAP_TICKS   = DefGapTicks
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CodeW*NUM_REQ-1:0] code,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     led
);

  localparam int unsigned Div    = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned MaxLen = max_u(PULSE_TICKS, GAP_TICKS);
  localparam int unsigned PhW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam logic [PhW-1:0] PulseLast = PhW'(PULSE_TICKS - 1);
  localparam logic [PhW-1:0] GapLast   = PhW'(GAP_TICKS - 1);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LedOn = 1'b0;
`else
  localparam logic LedOn = 1'b1;
`endif
  localparam logic LedOff = ~LedOn;

  if ((Div < 2) || (Div * TICK_HZ != CLK_FREQ_HZ)) begin : gen_bad_div
    $error("CLK_FREQ_HZ/TICK_HZ must be an exact integer of at least 2");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : gen_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end

  led_state_e           state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [CodeW-1:0]     pulse_q, pulse_d;
  logic [PhW-1:0]       phase_q;
  logic                 tick, clr, phase_end, higher, abort;
  logic [IdxW-1:0]      win;
  logic [CodeW-1:0]     win_code;
  logic                 led_d, busy_d;
  logic [NUM_REQ-1:0]   grant_d;

  // Every state entry restarts the time base so each phase is exactly LEN*Div cycles.
  assign clr = (state_d != state_q);

  led_tick_gen #(
    .DIV (Div)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .tick    (tick)
  );

  // Lowest set index wins; the loop runs downwards so the last hit is the winner.
  always_comb begin
    win      = '0;
    win_code = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win      = IdxW'(i);
        win_code = code[i*CodeW +: CodeW];
      end
    end
  end

  always_comb begin
    higher = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if ((i < int'(owner_q)) && req[i]) begin
        higher = 1'b1;
      end
    end
  end

  assign abort     = !req[owner_q];
  assign phase_end = tick && (phase_q == ((state_q == StGap) ? GapLast : PulseLast));

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      pulse_q <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pulse_q <= pulse_d;
      if (clr) begin
        phase_q <= '0;
      end else if (tick) begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  // Next-state logic; an abort wins over a phase end in the same cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pulse_d = pulse_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = win;
          if (win_code == SolidCode) begin
            state_d = StSolid;
          end else begin
            state_d = StOn;
            pulse_d = win_code;
          end
        end
      end
      StSolid: begin
        if (tick && (abort || higher)) state_d = StIdle;
      end
      StOn: begin
        if (abort) begin
          state_d = StIdle;
        end else if (phase_end) begin
          pulse_d = pulse_q - 1'b1;
          state_d = (pulse_q == 4'd1) ? StGap : StOff;
        end
      end
      StOff: begin
        if (abort) state_d = StIdle;
        else if (phase_end) state_d = StOn;
      end
      StGap: begin
        if (abort || phase_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    led_d   = ((state_d == StSolid) || (state_d == StOn)) ? LedOn : LedOff;
    busy_d  = (state_d != StIdle);
    grant_d = '0;
    if (state_d != StIdle) grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      led   <= LedOff;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      led   <= led_d;
      grant <= grant_d;
      busy  <= busy_d;
    end
  end

endmodule
